// File: rtl/mlp_serial.sv
`default_nettype none
// ============================================================================
// Module   : luts, mlp_serial
// Brief    : Two-layer quantised MLP with a serial element stream; optional
//            macro MLP_FC1_SAT_EN makes the FC1 accumulators saturate.
// Revision : 1.0 - initial release
// ============================================================================

module luts #(
  parameter int N1  = 98,
  parameter int N2  = 10,
  parameter int W_K = 4,
  parameter int W_Y = 16
) (
  output logic [N2-1:0][N1/2:0][W_K-1:0] weights_n1_mag,
  output logic [N2-1:0][N1/2:0][W_K-1:0] weights_n1_pol,
  output logic [N2:0][W_K-1:0]           weights_n2,
  output logic [2**W_K-1:0][W_Y-1:0]     tanh
);

  function automatic logic [W_K-1:0] wrap_k(input int v);
    return v[W_K-1:0];
  endfunction

  // Rational tanh approximation s/(|s|+1), scaled to full signed output range.
  function automatic logic [W_Y-1:0] tanh_entry(input int i);
    int s;
    int v;
    s = (i >= 2**(W_K-1)) ? i - 2**W_K : i;
    v = (s * (2**(W_Y-1) - 1)) / (((s < 0) ? -s : s) + 1);
    return v[W_Y-1:0];
  endfunction

  for (genvar n = 0; n < N2; n++) begin : g_n1_row
    for (genvar e = 0; e <= N1/2; e++) begin : g_n1_col
      assign weights_n1_mag[n][e] = wrap_k(n*5 + e*3 + 1);
      assign weights_n1_pol[n][e] = wrap_k(n*3 + e*7 + 2);
    end
  end

  for (genvar k = 0; k <= N2; k++) begin : g_n2
    assign weights_n2[k] = wrap_k(k*5 + 3);
  end

  for (genvar t = 0; t < 2**W_K; t++) begin : g_tanh
    assign tanh[t] = tanh_entry(t);
  end

endmodule

module mlp_serial #(
  parameter int N1  = 98,
  parameter int N2  = 10,
  parameter int P   = 2,
  parameter int W_X = 4,
  parameter int W_K = 4,
  parameter int W_Y = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [P-1:0][W_X-1:0] in_mag,
  input  logic [P-1:0][1:0]     in_pol,
  output logic [W_Y-1:0]        out,
  output logic                  out_vld
);

  localparam int N_ELEM    = N1/2 + 1;
  localparam int N_BEATS   = N_ELEM / P;
  localparam int W_SUM_FC1 = W_X + W_K + $clog2(N1/2);
  localparam int W_SUM_FC2 = W_X + W_K + $clog2(N2);
  localparam int W_WIDE    = W_SUM_FC1 + W_X + W_K;
  localparam int W_BEAT    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int W_ELEM    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int W_K2      = $clog2(N2 + 1);
  localparam int W_ACT     = W_X - 1;

  localparam logic signed [W_SUM_FC2-1:0] IDX_MAX = W_SUM_FC2'(2**(W_K-1) - 1);
  localparam logic signed [W_SUM_FC2-1:0] IDX_MIN = W_SUM_FC2'(-(2**(W_K-1)));
`ifdef MLP_FC1_SAT_EN
  localparam logic signed [W_WIDE-1:0] FC1_MAX = W_WIDE'(2**(W_SUM_FC1-1) - 1);
  localparam logic signed [W_WIDE-1:0] FC1_MIN = W_WIDE'(-(2**(W_SUM_FC1-1)));
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC  = 3'd1,
    S_ACT  = 3'd2,
    S_FC2  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  logic [N2-1:0][N1/2:0][W_K-1:0] w1_mag;
  logic [N2-1:0][N1/2:0][W_K-1:0] w1_pol;
  logic [N2:0][W_K-1:0]           w2;
  logic [2**W_K-1:0][W_Y-1:0]     tanh_lut;

  luts #(.N1(N1), .N2(N2), .W_K(W_K), .W_Y(W_Y)) u_luts (
    .weights_n1_mag (w1_mag),
    .weights_n1_pol (w1_pol),
    .weights_n2     (w2),
    .tanh           (tanh_lut)
  );

  state_t                       state_q, state_d;
  logic [W_BEAT-1:0]            beat_q, beat_d;
  logic [N2-1:0][W_SUM_FC1-1:0] acc_q, acc_d;
  logic [N2-1:0][W_ACT-1:0]     act_q, act_d;
  logic signed [W_SUM_FC2-1:0]  fc2_q, fc2_d;
  logic [W_K2-1:0]              k_q, k_d;
  logic [W_Y-1:0]               out_q, out_d;
  logic                         out_vld_q, out_vld_d;

  logic [N2-1:0][W_SUM_FC1-1:0] fc1_next;
  logic [N2-1:0][W_ACT-1:0]     act_clip;
  logic signed [W_WIDE-1:0]     fc1_sum, op_w, op_x;
  logic [W_ELEM-1:0]            elem;
  logic signed [W_SUM_FC2-1:0]  fc2_w, fc2_a;
  logic [W_K-1:0]               tanh_idx;

  // FC1 update for the beat currently on the bus, all neurons in parallel.
  always_comb begin
    fc1_next = acc_q;
    fc1_sum  = '0;
    op_w     = '0;
    op_x     = '0;
    elem     = '0;
    for (int n = 0; n < N2; n++) begin
      fc1_sum = W_WIDE'($signed(acc_q[n]));
      for (int p = 0; p < P; p++) begin
        elem    = W_ELEM'(int'(beat_q) * P + p);
        op_w    = W_WIDE'($signed(w1_mag[n][elem]));
        op_x    = W_WIDE'($signed(in_mag[p]));
        fc1_sum = fc1_sum + op_w * op_x;
        op_w    = W_WIDE'($signed(w1_pol[n][elem]));
        op_x    = W_WIDE'($signed(in_pol[p]));
        fc1_sum = fc1_sum + op_w * op_x;
      end
`ifdef MLP_FC1_SAT_EN
      if (fc1_sum > FC1_MAX) begin
        fc1_next[n] = FC1_MAX[W_SUM_FC1-1:0];
      end else if (fc1_sum < FC1_MIN) begin
        fc1_next[n] = FC1_MIN[W_SUM_FC1-1:0];
      end else begin
        fc1_next[n] = fc1_sum[W_SUM_FC1-1:0];
      end
`else
      fc1_next[n] = fc1_sum[W_SUM_FC1-1:0];
`endif
    end
  end

  // ReLU then clip: negative -> 0, anything above the activation range -> all ones.
  always_comb begin
    act_clip = '0;
    for (int n = 0; n < N2; n++) begin
      if (acc_q[n][W_SUM_FC1-1]) begin
        act_clip[n] = '0;
      end else if (acc_q[n][W_SUM_FC1-2:W_ACT] != '0) begin
        act_clip[n] = '1;
      end else begin
        act_clip[n] = acc_q[n][W_ACT-1:0];
      end
    end
  end

  assign fc2_w = W_SUM_FC2'($signed(w2[k_q]));
  assign fc2_a = W_SUM_FC2'(act_q[k_q]);

  always_comb begin
    if (fc2_q > IDX_MAX) begin
      tanh_idx = IDX_MAX[W_K-1:0];
    end else if (fc2_q < IDX_MIN) begin
      tanh_idx = IDX_MIN[W_K-1:0];
    end else begin
      tanh_idx = fc2_q[W_K-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    act_d     = act_q;
    fc2_d     = fc2_q;
    k_d       = k_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (in_vld) begin
          acc_d = fc1_next;
          if (beat_q == W_BEAT'(N_BEATS - 1)) begin
            beat_d  = '0;
            state_d = S_ACT;
          end else begin
            beat_d  = beat_q + W_BEAT'(1);
            state_d = S_ACC;
          end
        end
      end
      S_ACT: begin
        act_d   = act_clip;
        fc2_d   = W_SUM_FC2'($signed(w2[N2]));
        k_d     = '0;
        state_d = S_FC2;
      end
      S_FC2: begin
        fc2_d = fc2_q + fc2_w * fc2_a;
        k_d   = k_q + W_K2'(1);
        if (k_q == W_K2'(N2 - 1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_d     = tanh_lut[tanh_idx];
        out_vld_d = 1'b1;
        acc_d     = '0;
        beat_d    = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      acc_q     <= '0;
      act_q     <= '0;
      fc2_q     <= '0;
      k_q       <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      act_q     <= act_d;
      fc2_q     <= fc2_d;
      k_q       <= k_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_serial
// Brief    : Directed-vector bench for mlp_serial with a frame-level golden model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mlp_serial;

  localparam int N1        = 98;
  localparam int N2        = 10;
  localparam int P         = 2;
  localparam int W_X       = 4;
  localparam int W_K       = 4;
  localparam int W_Y       = 16;
  localparam int N_ELEM    = N1/2 + 1;
  localparam int N_BEATS   = N_ELEM / P;
  localparam int W_SUM_FC1 = 14;
  localparam int LAT       = N2 + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_vld = 1'b0;
  logic [P-1:0][W_X-1:0] in_mag = '0;
  logic [P-1:0][1:0]     in_pol = '0;
  logic [W_Y-1:0]        out;
  logic                  out_vld;

  mlp_serial #(.N1(N1), .N2(N2), .P(P), .W_X(W_X), .W_K(W_K), .W_Y(W_Y)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_mag  (in_mag),
    .in_pol  (in_pol),
    .out     (out),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  int hold     = 0;
  int busy     = 0;
  int el_m[$];
  int el_p[$];
  int exp_due[$];
  int exp_val[$];
  int fr_m[N_ELEM];
  int fr_p[N_ELEM];

  function automatic int sx(input int v, input int bits);
    int m;
    m = v % (1 << bits);
    if (m < 0) m = m + (1 << bits);
    return (m >= (1 << (bits - 1))) ? m - (1 << bits) : m;
  endfunction

  // Whole-frame reference: FC1 dot products, wrap, clip, FC2, saturate, tanh.
  function automatic int model_out(input int m[$], input int p[$]);
    int acc;
    int act;
    int fc2;
    int s;
    fc2 = sx(N2*5 + 3, W_K);
    for (int n = 0; n < N2; n++) begin
      acc = 0;
      for (int e = 0; e < N_ELEM; e++)
        acc += sx(n*5 + e*3 + 1, W_K) * m[e] + sx(n*3 + e*7 + 2, W_K) * p[e];
      acc = sx(acc, W_SUM_FC1);
      act = (acc < 0) ? 0 : ((acc > (1 << (W_X-1)) - 1) ? (1 << (W_X-1)) - 1 : acc);
      fc2 += sx(n*5 + 3, W_K) * act;
    end
    s = (fc2 > 7) ? 7 : ((fc2 < -8) ? -8 : fc2);
    return (s * ((1 << (W_Y-1)) - 1)) / (((s < 0) ? -s : s) + 1);
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      el_m.delete();
      el_p.delete();
      exp_due.delete();
      exp_val.delete();
      busy = 0;
      hold = 0;
    end else if (busy > 0) begin
      busy = busy - 1;
    end else if (in_vld) begin
      for (int p = 0; p < P; p++) begin
        el_m.push_back(int'($signed(in_mag[p])));
        el_p.push_back(int'($signed(in_pol[p])));
      end
      if (el_m.size() == N_ELEM) begin
        exp_due.push_back(cyc + LAT);
        exp_val.push_back(model_out(el_m, el_p));
        el_m.delete();
        el_p.delete();
        busy = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_vld) begin
        if (exp_due.size() != 0 && exp_due[0] == cyc) begin
          check("result", int'($signed(out)), exp_val[0]);
          hold = exp_val[0];
          void'(exp_due.pop_front());
          void'(exp_val.pop_front());
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL out_vld_timing: out_vld=1 at cycle %0d, expected 0", cyc);
        end
      end else begin
        if (exp_due.size() != 0 && exp_due[0] <= cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_vld_missing: out_vld=0 at cycle %0d, expected 1", cyc);
          void'(exp_due.pop_front());
          void'(exp_val.pop_front());
        end
        check("out_hold", int'($signed(out)), hold);
      end
    end
  end

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_vld = 1'b0;
      in_mag = W_X*P'($urandom);
      in_pol = 2*P'($urandom);
    end
  endtask

  task automatic drive_beat(input int b);
    @(negedge clk);
    in_vld = 1'b1;
    for (int p = 0; p < P; p++) begin
      in_mag[p] = W_X'(fr_m[b*P + p]);
      in_pol[p] = 2'(fr_p[b*P + p]);
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int b = 0; b < N_BEATS; b++) begin
      if (gaps) go_idle($urandom_range(1, 3));
      drive_beat(b);
    end
    go_idle(1);
  endtask

  task automatic fill_const(input int m, input int p);
    for (int e = 0; e < N_ELEM; e++) begin
      fr_m[e] = m;
      fr_p[e] = p;
    end
  endtask

  task automatic fill_rand();
    for (int e = 0; e < N_ELEM; e++) begin
      fr_m[e] = sx(int'($urandom_range(0, 15)), W_X);
      fr_p[e] = sx(int'($urandom_range(0, 3)), 2);
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (exp_due.size() != 0 && t < 4*LAT) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_due.size() != 0) begin
      n_fail++;
      $display("FAIL %s: result pending after %0d cycles, expected none pending", name, t);
    end
    go_idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_out", int'(out), 0);
    check("reset_out_vld", int'(out_vld), 0);
    go_idle(2);

    fill_const(0, 0);
    send_frame(1'b0);
    wait_done("zero_frame");
    check("lit_zero_frame", int'($signed(out)), 27305);

    fill_const(0, 0);
    fr_m[0] = 1;
    send_frame(1'b0);
    wait_done("elem0_mag1");
    check("lit_elem0_mag1", int'($signed(out)), 28671);

    fill_const(0, 0);
    fr_m[1] = -1;
    send_frame(1'b0);
    wait_done("elem1_magm1");
    check("lit_elem1_magm1", int'($signed(out)), -29126);

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      send_frame(1'b0);
      wait_done("rand_contig");
      send_frame(1'b1);
      wait_done("rand_gaps");
    end

    fill_rand();
    for (int b = 0; b < 10; b++) drive_beat(b);
    @(negedge clk);
    rst = 1'b1;
    in_vld = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_vld = 1'b0;
    check("midframe_reset_out", int'(out), 0);
    fill_rand();
    send_frame(1'b0);
    wait_done("fresh_after_reset");

    fill_const(7, 1);
    send_frame(1'b0);
    wait_done("all_max");
    check("lit_all_max", int'($signed(out)), 27305);

    fill_rand();
    for (int b = 0; b < N_BEATS; b++) drive_beat(b);
    fill_rand();
    for (int i = 0; i < LAT + N_BEATS; i++) drive_beat(i % N_BEATS);
    go_idle(1);
    wait_done("back_to_back");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlp_serial.md
Name: mlp_serial

Overview:
- Two-layer quantised MLP inference block with a serial input stream.
- One frame is N_ELEM = N1/2+1 elements (50 at defaults). Each element carries a signed magnitude and a signed 2-bit polarity.
- Frame arrives P elements per beat over N_BEATS = N_ELEM/P beats (25 at defaults). Precondition: P divides N_ELEM.
- Pipeline: FC1 (N2 neurons, accumulated on the fly) -> ReLU/clip -> FC2 (single neuron plus bias) -> tanh LUT -> one W_Y result per frame.
- All constants come from an internal instance of sub-block luts.

Parameters:
- N1, 98: input dimension; frame holds N1/2+1 elements.
- N2, 10: FC1 neuron count.
- P, 2: elements per input beat.
- W_X, 4: element magnitude width.
- W_K, 4: weight width; tanh LUT has 2**W_K entries.
- W_Y, 16: output width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_vld  in  1  beat valid.
- in_mag  in  P*W_X  packed [P-1:0][W_X-1:0]; lane p is element 2*beat+p.
- in_pol  in  P*2  packed [P-1:0][1:0]; per-lane polarity.
- out  out  W_Y  tanh LUT result.
- out_vld  out  1  one-cycle result strobe.
- Single clock clk. Reset rst is synchronous and active-high.

Behaviour:
- luts sub-block, pure constant outputs:
  - weights_n1_mag [N2-1:0][N1/2:0][W_K-1:0]
  - weights_n1_pol [N2-1:0][N1/2:0][W_K-1:0]
  - weights_n2 [N2:0][W_K-1:0]; index N2 is the FC2 bias.
  - tanh [2**W_K-1:0][W_Y-1:0]
- All operands are treated as two's-complement: mag, pol, every weight.
- FC1, for each n2: acc[n2] += Σ_p ( w_mag[n2][e]*mag_p + w_pol[n2][e]*pol_p ), where e = element index.
  - Accumulator width W_SUM_FC1 = W_X+W_K+$clog2(N1/2) (14 at defaults).
  - Overflow wraps modulo 2^W_SUM_FC1.
- State IDLE/ACC: each cycle with in_vld=1 accepts one beat and increments the beat counter. Gaps (in_vld=0) are allowed and do not advance anything.
- On acceptance of beat N_BEATS-1 -> state ACT at the next edge. Beats received outside IDLE/ACC are ignored.
- ACT, 1 cycle: act[n2] = clamp(acc[n2], 0, 2^(W_X-1)-1), i.e. ReLU then unsigned saturate to 0..7 at defaults.
  - FC2 accumulator is loaded with sign-extended weights_n2[N2].
- FC2, N2 cycles: cycle k adds weights_n2[k]*act[k].
  - Accumulator width W_SUM_FC2 = W_X+W_K+$clog2(N2) (12 at defaults).
- OUT, 1 cycle:
  - idx = FC2 sum saturated to signed W_K range [-8,7], taken as its W_K-bit two's-complement pattern.
  - out <= tanh[idx]; out_vld <= 1.
  - FC1 accumulators and beat counter clear; return to IDLE.
- Latency: out_vld rises N2+2 cycles after the edge that accepts the last beat. It is high for exactly 1 cycle.
- out holds its value until the next frame's result.
- Reset:
  - Clears all accumulators and the beat counter; state IDLE.
  - out=0, out_vld=0.
  - Reset mid-frame discards the partial frame; no out_vld for it.
- Reset in the same cycle as in_vld=1: reset wins and the beat is dropped.

Optional Feature:
- Macro MLP_FC1_SAT_EN.
- Defined: FC1 accumulators saturate at ±(2^(W_SUM_FC1-1)) bounds instead of wrapping.
- Undefined (default): wrap-around arithmetic as above.
- Bench golden model assumes the undefined build.

Test Plan:
- Reset 2 cycles, idle 2, then 25 contiguous beats of all-zero mag/pol:
  - out_vld pulses once, 12 cycles after the last beat.
  - out = tanh[sat4(bias)], where bias = weights_n2[10].
- 25 random beats, model-checked:
  - out_vld pulses once, 12 cycles after the last beat.
  - Golden model pops elements in order lane0 then lane1 per beat and computes fc1[n2] = Σ w_mag*mag + w_pol*pol in 14-bit wrap.
  - out equals model through ReLU/clip, FC2 and tanh.
- Same frame with random 1-3 cycle in_vld gaps -> identical out to the contiguous run; out_vld delay still 12 cycles after the last accepted beat.
- Assert rst after beat 10 of a frame, then send a full fresh frame -> exactly one out_vld, matching the fresh frame only.
- All mag=4'h7, all pol=2'b01 -> out matches wrap-model value.
- Two back-to-back frames with in_vld asserted during the ACT/FC2 cycles:
  - Those beats are dropped.
  - Second frame's result matches only beats accepted after return to IDLE.
